// File: rtl/mrp_tx_noc_out_pkg.sv
// Shared definitions for the MRP transmit NoC egress: header flit layout,
// FSM state encodings, flit-select codes and the bytes-per-flit derivation.
package mrp_tx_noc_out_pkg;

  localparam logic [7:0] MRP_MSG_TYPE = 8'h2d;

  // Header occupies the low bits of the flit, dst_x most significant.
  typedef struct packed {
    logic [7:0]  dst_x;
    logic [7:0]  dst_y;
    logic [7:0]  src_x;
    logic [7:0]  src_y;
    logic [15:0] msg_len;
    logic [7:0]  msg_type;
  } hdr_flit_t;

  localparam int HDR_W = $bits(hdr_flit_t);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_META = 2'd2;
  localparam logic [1:0] ST_DATA = 2'd3;

  typedef enum logic [1:0] {
    SEL_HDR  = 2'd0,
    SEL_META = 2'd1,
    SEL_DATA = 2'd2
  } flit_sel_e;

  function automatic int bpf_log2(input int noc_data_w);
    return $clog2(noc_data_w / 8);
  endfunction

endpackage

// File: rtl/mrp_tx_noc_out_ctrl.sv
// Message sequencing FSM for the MRP egress: descriptor accept, header, meta,
// then payload pass-through; drives all handshakes and datapath strobes.
module mrp_tx_noc_out_ctrl
  import mrp_tx_noc_out_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hdr_val_i,
  input  logic      data_val_i,
  input  logic      noc_rdy_i,
  input  logic      zero_flits_i,
  input  logic      cnt_last_i,
  output logic      hdr_rdy_o,
  output logic      data_rdy_o,
  output logic      noc_val_o,
  output logic      load_desc_o,
  output logic      load_cnt_o,
  output logic      dec_cnt_o,
  output flit_sel_e sel_o
);

  logic [1:0] state_q, state_d;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    hdr_rdy_o   = 1'b0;
    data_rdy_o  = 1'b0;
    noc_val_o   = 1'b0;
    load_desc_o = 1'b0;
    load_cnt_o  = 1'b0;
    dec_cnt_o   = 1'b0;
    sel_o       = SEL_META;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          hdr_rdy_o = 1'b1;
          if (hdr_val_i) begin
            load_desc_o = 1'b1;
            state_d     = ST_HDR;
          end
        end
        ST_HDR: begin
          noc_val_o = 1'b1;
          sel_o     = SEL_HDR;
          if (noc_rdy_i) state_d = ST_META;
        end
        ST_META: begin
          noc_val_o = 1'b1;
          sel_o     = SEL_META;
          if (noc_rdy_i) begin
            if (zero_flits_i) begin
              state_d = ST_IDLE;
            end else begin
              load_cnt_o = 1'b1;
              state_d    = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          noc_val_o  = data_val_i;
          data_rdy_o = noc_rdy_i;
          sel_o      = SEL_DATA;
          if (data_val_i && noc_rdy_i) begin
            dec_cnt_o = 1'b1;
            if (cnt_last_i) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mrp_tx_noc_out_datap.sv
// Descriptor registers, payload flit-count calculation, remaining-flit
// down-counter and the outgoing flit multiplexer.
module mrp_tx_noc_out_datap
  import mrp_tx_noc_out_pkg::*;
#(
  parameter int NOC_DATA_W = 512,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_desc_i,
  input  logic                  load_cnt_i,
  input  logic                  dec_cnt_i,
  input  flit_sel_e             sel_i,
  input  logic [7:0]            dst_x_i,
  input  logic [7:0]            dst_y_i,
  input  logic [NOC_DATA_W-17:0] meta_i,
  input  logic [15:0]           len_i,
  input  logic [NOC_DATA_W-1:0] data_i,
  output logic                  zero_flits_o,
  output logic                  cnt_last_o,
  output logic [NOC_DATA_W-1:0] flit_o
);

  localparam int          LOG2_BPF = bpf_log2(NOC_DATA_W);
  localparam logic [16:0] BPF_M1   = 17'((1 << LOG2_BPF) - 1);

  logic [7:0]            dst_x_q, dst_y_q;
  logic [NOC_DATA_W-17:0] meta_q;
  logic [15:0]           len_q;
  logic [10:0]           flits_q, cnt_q;
  logic [16:0]           flits_sum;
  logic [10:0]           flits_d;
  hdr_flit_t             hdr;

  // 17-bit sum keeps ceil(len/BPF) exact for len = 0xFFFF.
  assign flits_sum = {1'b0, len_i} + BPF_M1;
  assign flits_d   = 11'(flits_sum >> LOG2_BPF);

  // NOTE: descriptor registers are reset as well, so idle output flits are
  // defined values rather than X from never-written storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_x_q <= '0;
      dst_y_q <= '0;
      meta_q  <= '0;
      len_q   <= '0;
      flits_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (load_desc_i) begin
        dst_x_q <= dst_x_i;
        dst_y_q <= dst_y_i;
        meta_q  <= meta_i;
        len_q   <= len_i;
        flits_q <= flits_d;
      end
      if (load_cnt_i)     cnt_q <= flits_q;
      else if (dec_cnt_i) cnt_q <= cnt_q - 11'd1;
    end
  end

  assign zero_flits_o = (flits_q == '0);
  assign cnt_last_o   = (cnt_q == 11'd1);

  assign hdr = '{
    dst_x:    dst_x_q,
    dst_y:    dst_y_q,
    src_x:    8'(SRC_X),
    src_y:    8'(SRC_Y),
    msg_len:  16'(flits_q) + 16'd1,
    msg_type: MRP_MSG_TYPE
  };

  always_comb begin
    case (sel_i)
      SEL_HDR:  flit_o = {{(NOC_DATA_W-HDR_W){1'b0}}, hdr};
      SEL_DATA: flit_o = data_i;
      default:  flit_o = {len_q, meta_q};
    endcase
  end

endmodule

// File: rtl/mrp_tx_noc_out.sv
// MRP tile transmit egress: takes one descriptor from the engine and emits
// header, meta and payload flits on noc0 in the order the MRP ingress expects.
module mrp_tx_noc_out
  import mrp_tx_noc_out_pkg::*;
#(
  parameter int NOC_DATA_W = 512,
  parameter int SRC_X      = 0,
  parameter int SRC_Y      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mrp_engine_tx_out_hdr_val,
  output logic                   tx_out_mrp_engine_hdr_rdy,
  input  logic [7:0]             mrp_engine_tx_out_dst_x,
  input  logic [7:0]             mrp_engine_tx_out_dst_y,
  input  logic [NOC_DATA_W-17:0] mrp_engine_tx_out_meta,
  input  logic [15:0]            mrp_engine_tx_out_len,
  input  logic                   mrp_engine_tx_out_data_val,
  input  logic [NOC_DATA_W-1:0]  mrp_engine_tx_out_data,
  output logic                   tx_out_mrp_engine_data_rdy,
  output logic                   tx_out_noc0_vrtoc_val,
  output logic [NOC_DATA_W-1:0]  tx_out_noc0_vrtoc_data,
  input  logic                   noc0_vrtoc_tx_out_rdy
);

  logic      load_desc, load_cnt, dec_cnt, zero_flits, cnt_last;
  flit_sel_e sel;

  mrp_tx_noc_out_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .hdr_val_i    (mrp_engine_tx_out_hdr_val),
    .data_val_i   (mrp_engine_tx_out_data_val),
    .noc_rdy_i    (noc0_vrtoc_tx_out_rdy),
    .zero_flits_i (zero_flits),
    .cnt_last_i   (cnt_last),
    .hdr_rdy_o    (tx_out_mrp_engine_hdr_rdy),
    .data_rdy_o   (tx_out_mrp_engine_data_rdy),
    .noc_val_o    (tx_out_noc0_vrtoc_val),
    .load_desc_o  (load_desc),
    .load_cnt_o   (load_cnt),
    .dec_cnt_o    (dec_cnt),
    .sel_o        (sel)
  );

  mrp_tx_noc_out_datap #(
    .NOC_DATA_W (NOC_DATA_W),
    .SRC_X      (SRC_X),
    .SRC_Y      (SRC_Y)
  ) u_datap (
    .clk          (clk),
    .rst          (rst),
    .load_desc_i  (load_desc),
    .load_cnt_i   (load_cnt),
    .dec_cnt_i    (dec_cnt),
    .sel_i        (sel),
    .dst_x_i      (mrp_engine_tx_out_dst_x),
    .dst_y_i      (mrp_engine_tx_out_dst_y),
    .meta_i       (mrp_engine_tx_out_meta),
    .len_i        (mrp_engine_tx_out_len),
    .data_i       (mrp_engine_tx_out_data),
    .zero_flits_o (zero_flits),
    .cnt_last_o   (cnt_last),
    .flit_o       (tx_out_noc0_vrtoc_data)
  );

endmodule

// File: tb/tb_mrp_tx_noc_out.sv
// Directed self-checking bench for mrp_tx_noc_out with a 512-bit NoC
// (64 bytes per flit), tile coordinates (3,5).
module tb_mrp_tx_noc_out;

  localparam int         W     = 512;
  localparam int         MW    = W - 16;
  localparam int         SX    = 3;
  localparam int         SY    = 5;
  localparam logic [7:0] MRP_T = 8'h2d;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hdr_val = 1'b0;
  logic          hdr_rdy;
  logic [7:0]    dst_x = '0, dst_y = '0;
  logic [MW-1:0] meta = '0;
  logic [15:0]   len = '0;
  logic          data_val = 1'b0;
  logic [W-1:0]  data = '0;
  logic          data_rdy;
  logic          noc_val;
  logic [W-1:0]  noc_data;
  logic          noc_rdy = 1'b1;

  mrp_tx_noc_out #(.NOC_DATA_W(W), .SRC_X(SX), .SRC_Y(SY)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .mrp_engine_tx_out_hdr_val  (hdr_val),
    .tx_out_mrp_engine_hdr_rdy  (hdr_rdy),
    .mrp_engine_tx_out_dst_x    (dst_x),
    .mrp_engine_tx_out_dst_y    (dst_y),
    .mrp_engine_tx_out_meta     (meta),
    .mrp_engine_tx_out_len      (len),
    .mrp_engine_tx_out_data_val (data_val),
    .mrp_engine_tx_out_data     (data),
    .tx_out_mrp_engine_data_rdy (data_rdy),
    .tx_out_noc0_vrtoc_val      (noc_val),
    .tx_out_noc0_vrtoc_data     (noc_data),
    .noc0_vrtoc_tx_out_rdy      (noc_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] exp_q[$];
  logic [W-1:0] data_q[$];
  int           fcyc[$];
  int           acc_q[$];
  int           cyc       = 0;
  int           drdy_cnt  = 0;
  int           stall_pct = 0;
  int           gap_pct   = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_flit  = '0;

  always @(posedge clk) cyc++;

  // Engine data source and NoC sink, re-driven shortly after each edge.
  always @(posedge clk) begin
    #2;
    noc_rdy = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    if (data_q.size() > 0) begin
      data     = data_q[0];
      data_val = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
    end else begin
      data_val = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (data_rdy) drdy_cnt++;
    if (hdr_val && hdr_rdy) acc_q.push_back(cyc);
    if (noc_val && prev_stall) check("stall_hold", noc_data, prev_flit);
    prev_stall = noc_val && !noc_rdy;
    prev_flit  = noc_data;
    if (noc_val && noc_rdy) begin
      fcyc.push_back(cyc);
      if (exp_q.size() == 0) check("extra_flit", W'(noc_val), '0);
      else                   check("flit", noc_data, exp_q.pop_front());
    end
    if (data_val && data_rdy) void'(data_q.pop_front());
  end

  function automatic logic [W-1:0] rnd_flit();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int nflits(input logic [15:0] l);
    return (int'(l) + 63) / 64;
  endfunction

  function automatic logic [W-1:0] mk_hdr(input logic [7:0] dx, input logic [7:0] dy,
                                          input logic [15:0] l);
    logic [W-1:0] f;
    f        = '0;
    f[55:48] = dx;
    f[47:40] = dy;
    f[39:32] = 8'(SX);
    f[31:24] = 8'(SY);
    f[23:8]  = 16'(nflits(l) + 1);
    f[7:0]   = MRP_T;
    return f;
  endfunction

  // Queues expectations and engine payload, then presents the descriptor.
  task automatic send_msg(input logic [7:0] dx, input logic [7:0] dy, input logic [15:0] l);
    logic [W-1:0] tmp;
    logic [W-1:0] p;
    tmp = rnd_flit();
    exp_q.push_back(mk_hdr(dx, dy, l));
    exp_q.push_back({l, tmp[MW-1:0]});
    for (int i = 0; i < nflits(l); i++) begin
      p = rnd_flit();
      exp_q.push_back(p);
      data_q.push_back(p);
    end
    dst_x   = dx;
    dst_y   = dy;
    meta    = tmp[MW-1:0];
    len     = l;
    hdr_val = 1'b1;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_q.size() < n && b < 200) begin
      @(negedge clk); #1;
      b++;
    end
    check("accept", W'(acc_q.size()), W'(n));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (exp_q.size() > 0 && b < budget) begin
      @(negedge clk); #1;
      b++;
    end
    check("drain", W'(exp_q.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bf, ba, bd, t, n0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hdr_rdy", W'(hdr_rdy), '0);
    check("rst_data_rdy", W'(data_rdy), '0);
    check("rst_noc_val", W'(noc_val), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_hdr_rdy", W'(hdr_rdy), W'(1));

    // len=100: header msg_len=3, meta, 2 payload flits back to back
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'h12, 8'h34, 16'd100);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    wait_done(50);
    check("t1_busy_hdr_rdy", W'(hdr_rdy), '0);
    @(negedge clk);
    check("t1_idle_hdr_rdy", W'(hdr_rdy), W'(1));
    t = acc_q[ba];
    check("t1_nflits", W'(fcyc.size() - bf), W'(4));
    check("t1_hdr_cyc", W'(fcyc[bf] - t), W'(1));
    check("t1_meta_cyc", W'(fcyc[bf+1] - t), W'(2));
    check("t1_p0_cyc", W'(fcyc[bf+2] - t), W'(3));
    check("t1_p1_cyc", W'(fcyc[bf+3] - t), W'(4));

    // len=0: header + meta only, data_rdy never raised
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size(); bd = drdy_cnt;
    send_msg(8'hA0, 8'h0B, 16'd0);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    wait_done(20);
    @(negedge clk);
    check("t2_idle_hdr_rdy", W'(hdr_rdy), W'(1));
    check("t2_nflits", W'(fcyc.size() - bf), W'(2));
    check("t2_data_rdy", W'(drdy_cnt - bd), '0);

    // len=0xFFFF: 1024 payload flits, msg_len=1025
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'hFF, 8'hFE, 16'hFFFF);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    wait_done(1200);
    check("t3_nflits", W'(fcyc.size() - bf), W'(1026));
    check("t3_span", W'(fcyc[bf+1025] - fcyc[bf]), W'(1025));

    // Random NoC stalls and engine gaps over a 10-flit message
    stall_pct = 50; gap_pct = 30;
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'h07, 8'h09, 16'd601);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    wait_done(600);
    check("t4_nflits", W'(fcyc.size() - bf), W'(12));
    stall_pct = 0; gap_pct = 0;
    repeat (2) @(negedge clk);

    // Back-to-back: second descriptor held valid during the first message
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'h21, 8'h22, 16'd128);
    wait_acc(ba + 1);
    send_msg(8'h31, 8'h32, 16'd64);
    wait_acc(ba + 2);
    hdr_val = 1'b0;
    wait_done(50);
    check("t5_nflits", W'(fcyc.size() - bf), W'(7));
    check("t5_acc2_cyc", W'(acc_q[ba+1] - fcyc[bf+3]), W'(1));
    check("t5_gap", W'(fcyc[bf+4] - fcyc[bf+3]), W'(2));

    // Reset during DATA_OUT of a 5-flit message aborts it
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'h41, 8'h42, 16'd320);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    t = 0;
    while (fcyc.size() < bf + 4 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    check("t6_progress", W'(fcyc.size()), W'(bf + 4));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    data_q.delete();
    n0 = fcyc.size();
    @(negedge clk);
    check("t6_rst_noc_val", W'(noc_val), '0);
    check("t6_rst_data_rdy", W'(data_rdy), '0);
    check("t6_rst_hdr_rdy", W'(hdr_rdy), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_no_flits", W'(fcyc.size()), W'(n0));
    check("t6_idle_hdr_rdy", W'(hdr_rdy), W'(1));
    @(posedge clk); #1;
    bf = fcyc.size(); ba = acc_q.size();
    send_msg(8'h51, 8'h52, 16'd130);
    wait_acc(ba + 1);
    hdr_val = 1'b0;
    wait_done(50);
    check("t6_nflits", W'(fcyc.size() - bf), W'(5));
    repeat (3) @(negedge clk);
    check("t6_no_extra", W'(fcyc.size() - bf), W'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mrp_tx_noc_out.md
# mrp_tx_noc_out

Transmit-side NoC egress for the MRP tile. Accepts one message descriptor from the MRP engine, then streams it onto noc0 (vr-to-ctovr direction) as a header flit, a meta flit, and N payload flits taken from the engine's data stream. It mirrors the MRP receive ingress: the flit sequence it emits is exactly the sequence that ingress consumes.

## Interface
Parameters:
- NOC_DATA_W, 512, NoC flit width in bits; payload bytes per flit BPF = NOC_DATA_W/8.
- SRC_X, 0, this tile's X coordinate, written into the header flit.
- SRC_Y, 0, this tile's Y coordinate, written into the header flit.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mrp_engine_tx_out_hdr_val  in  1  descriptor valid
- tx_out_mrp_engine_hdr_rdy  out  1  descriptor accepted when val & rdy
- mrp_engine_tx_out_dst_x / _dst_y  in  8 each  destination tile coordinates
- mrp_engine_tx_out_meta  in  NOC_DATA_W-16  opaque MRP metadata (conn id, addresses)
- mrp_engine_tx_out_len  in  16  payload length in bytes
- mrp_engine_tx_out_data_val  in  1  payload flit valid
- mrp_engine_tx_out_data  in  NOC_DATA_W  payload flit
- tx_out_mrp_engine_data_rdy  out  1  payload flit consumed
- tx_out_noc0_vrtoc_val  out  1  NoC flit valid
- tx_out_noc0_vrtoc_data  out  NOC_DATA_W  NoC flit
- noc0_vrtoc_tx_out_rdy  in  1  NoC ready

## Operation
- States: IDLE, HDR_OUT, META_OUT, DATA_OUT.
- IDLE: hdr_rdy = 1 (0 while rst). On val: register dst, meta, len; data_flits = ceil(len/BPF) (11-bit; computed as (len + BPF-1) >> log2(BPF) in 17-bit arithmetic, no overflow at len=0xFFFF); go HDR_OUT.
- HDR_OUT: noc val = 1, data = header flit: dst_x, dst_y, SRC_X, SRC_Y, msg_type = MRP, msg_len = 1 + data_flits (meta + payload flits). On noc rdy -> META_OUT.
- META_OUT: noc val = 1, data = {len, meta}. On noc rdy: data_flits == 0 -> IDLE, else load remaining counter = data_flits, -> DATA_OUT.
- DATA_OUT: combinational pass-through; noc val = data_val, noc data = engine data, data_rdy = noc rdy. On data_val & noc rdy: decrement counter; if counter == 1 -> IDLE.
- Counter is authoritative for the flit count; the engine must present exactly data_flits flits. Bytes beyond len in the last flit are sent unmodified.
- data_rdy = 0 outside DATA_OUT; engine data is never consumed early.
- Output values while not valid are don't-care, but held at registered values (no X).

## Timing
- Reset: state IDLE, counter 0; hdr_rdy, data_rdy, and noc val all 0 while rst is high.
- Descriptor accepted at cycle t. Header flit valid at t+1; meta flit earliest t+2; first payload flit earliest t+3.
- Payload flits at 1 per cycle under full handshake.
- The earliest next-descriptor acceptance is in the cycle after the last flit handshake: there is one IDLE cycle between messages.
- NoC backpressure holds header and meta flits stable until rdy.
- A zero-length message emits exactly 2 flits, with msg_len = 1.
- rst asserted mid-message aborts it: state returns to IDLE on the next edge, and no further flits of that message are emitted.

## Structure
- Shared package: MRP msg_type constant, header-flit field struct (dst/src coords, msg_len, msg_type), state enum, and the BPF constant derivation.
- Natural split: mrp_tx_noc_out_ctrl (FSM, handshake muxing) plus mrp_tx_noc_out_datap (descriptor registers, flit-count calc, down-counter, output flit mux). Both are instantiated in mrp_tx_noc_out.

## Test plan
- len=100, BPF=64, no backpressure -> header msg_len=3, then meta, then 2 payload flits on consecutive cycles from t+1; hdr_rdy high again at the cycle after the last flit.
- len=0 -> exactly 2 flits (header msg_len=1, meta); data_rdy never asserted; back to IDLE.
- len=0xFFFF -> data_flits=1024, msg_len=1025; exactly 1024 payload handshakes.
- Random noc rdy stalls (50%) plus random data_val gaps over a 10-flit message -> flit order and contents exact; no duplicates or drops; header and meta stable while stalled.
- Back-to-back descriptors: the second hdr_val is held high during the first message -> it is accepted only in IDLE; the second header follows the first's last flit after exactly one gap cycle.
- rst pulsed during DATA_OUT of a 5-flit message -> no flits emitted after reset; a new descriptor after reset produces a correct, complete message.
